nibble_serial_adder: RTL and testbench



---
 rtl/nibble_pkg.sv | 8 +
 rtl/rcadder_4.sv | 16 +
 rtl/nibble_serial_adder.sv | 101 ++++++++++
 tb/tb_nibble_serial_adder.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/nibble_pkg.sv
// nibble_pkg: shared constants, FSM state type and counter sizing for the serial adder
package nibble_pkg;
  localparam int NIBBLE_W = 4;
  typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_e;
  function automatic int cnt_w(input int nibbles);
    return nibbles > 1 ? $clog2(nibbles) : 1;
  endfunction
endpackage

// File: rtl/rcadder_4.sv
// rcadder_4: 4-bit combinational ripple-carry adder
module rcadder_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [4:0] c;
  assign c[0] = ci;
  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign co = c[4];
endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit add, one nibble per cycle through a single rcadder_4
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  import nibble_pkg::*;
  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int CW = cnt_w(NIBBLES);
  state_e state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic carry_q, carry_d, a_msb_q, a_msb_d, b_msb_q, b_msb_d;
  logic cout_q, cout_d, ovf_q, ovf_d;
  logic [NIBBLE_W-1:0] nib_s;
  logic nib_co;
  rcadder_4 u_add (
    .a (a_q[NIBBLE_W-1:0]),
    .b (b_q[NIBBLE_W-1:0]),
    .ci(carry_q),
    .s (nib_s),
    .co(nib_co)
  );
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    if (state_q == S_IDLE && in_valid) begin
      a_d     = a;
      b_d     = b;
      carry_d = cin;
      a_msb_d = a[WIDTH-1];
      b_msb_d = b[WIDTH-1];
      cnt_d   = '0;
      state_d = S_ADD;
    end else if (state_q == S_ADD) begin
      a_d     = a_q >> NIBBLE_W;
      b_d     = b_q >> NIBBLE_W;
      carry_d = nib_co;
      cnt_d   = cnt_q + 1'b1;
      for (int i = 0; i < NIBBLES; i++)
        if (cnt_q == CW'(i)) sum_d[i*NIBBLE_W +: NIBBLE_W] = nib_s;
      // result flags are captured with the top nibble so they stay stable until the next DONE
      if (cnt_q == CW'(NIBBLES - 1)) begin
        state_d = S_DONE;
        cout_d  = nib_co;
        ovf_d   = (a_msb_q == b_msb_q) && (nib_s[NIBBLE_W-1] != a_msb_q);
      end
    end else if (state_q == S_DONE && out_ready) begin
      state_d = S_IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end
  assign in_ready  = state_q == S_IDLE;
  assign out_valid = state_q == S_DONE;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: directed self-checking bench for nibble_serial_adder at WIDTH=16
module tb_nibble_serial_adder;
  logic clk = 0, rst = 1, in_valid = 0, cin = 0, out_ready = 1;
  logic in_ready, out_valid, cout, ovf;
  logic [15:0] a = 0, b = 0, sum;
  int tests = 0, fails = 0;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  // presents one operand set in IDLE and waits (bounded) for out_valid; lat counts edges after acceptance
  task automatic run_op(input logic [15:0] x, y, input logic c,
                        output logic [15:0] s, output logic co, o, output int lat);
    a = x; b = y; cin = c; in_valid = 1; lat = 0;
    step();
    in_valid = 0;
    while (!out_valid && lat < 20) begin step(); lat++; end
    s = sum; co = cout; o = ovf;
  endtask

  task automatic test_reset();
    rst = 1; #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    tests++; if ({sum, cout, ovf} !== 18'h0) begin fails++; $display("FAIL reset_outputs: got sum=%h cout=%b ovf=%b want 0", sum, cout, ovf); end
    step(); step();
    rst = 0;
    step();
  endtask

  task automatic test_basic();
    logic [15:0] s; logic c, o; int lat;
    run_op(16'h00FF, 16'h0001, 1'b0, s, c, o, lat);
    tests++; if (lat !== 4) begin fails++; $display("FAIL basic_latency: got %0d edges want 4", lat); end
    tests++; if ({s, c, o} !== {16'h0100, 1'b0, 1'b0}) begin fails++; $display("FAIL basic_result: got %h/%b/%b want 0100/0/0", s, c, o); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL basic_done_ready: got %b want 0", in_ready); end
    step();
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL basic_one_cycle: got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_carry();
    logic [15:0] s; logic c, o; int lat;
    run_op(16'hFFFF, 16'h0001, 1'b0, s, c, o, lat); step();
    tests++; if ({s, c, o} !== {16'h0000, 1'b1, 1'b0}) begin fails++; $display("FAIL carry_wrap: got %h/%b/%b want 0000/1/0", s, c, o); end
    run_op(16'h1234, 16'h4321, 1'b1, s, c, o, lat); step();
    tests++; if ({s, c, o} !== {16'h5556, 1'b0, 1'b0}) begin fails++; $display("FAIL carry_no_stale: got %h/%b/%b want 5556/0/0", s, c, o); end
  endtask

  task automatic test_overflow();
    logic [15:0] s; logic c, o; int lat;
    run_op(16'h7FFF, 16'h0001, 1'b0, s, c, o, lat); step();
    tests++; if ({s, c, o} !== {16'h8000, 1'b0, 1'b1}) begin fails++; $display("FAIL ovf_pos: got %h/%b/%b want 8000/0/1", s, c, o); end
    run_op(16'h8000, 16'h8000, 1'b0, s, c, o, lat); step();
    tests++; if ({s, c, o} !== {16'h0000, 1'b1, 1'b1}) begin fails++; $display("FAIL ovf_neg: got %h/%b/%b want 0000/1/1", s, c, o); end
  endtask

  task automatic test_backpressure();
    int n = 0;
    out_ready = 0;
    a = 16'h1111; b = 16'h2222; cin = 0; in_valid = 1;
    step();
    a = 16'hAAAA; b = 16'hAAAA; cin = 1;
    while (!out_valid && n < 20) begin step(); n++; end
    tests++; if (n !== 4) begin fails++; $display("FAIL bp_latency: got %0d edges want 4", n); end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if ({out_valid, in_ready, sum, cout, ovf} !== {1'b1, 1'b0, 16'h3333, 1'b0, 1'b0}) begin
        fails++; $display("FAIL bp_hold%0d: got v=%b r=%b %h/%b/%b want 1/0/3333/0/0", i, out_valid, in_ready, sum, cout, ovf);
      end
      step();
    end
    in_valid = 0; out_ready = 1;
    step();
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL bp_release: got v=%b r=%b want 0/1", out_valid, in_ready); end
    step();
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_no_accept: got in_ready=%b want 1", in_ready); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] s; logic c, o; int lat;
    a = 16'hFFFF; b = 16'hFFFF; cin = 0; in_valid = 1;
    step();
    in_valid = 0;
    step();
    rst = 1; #1;
    tests++; if ({out_valid, in_ready, sum, cout, ovf} !== {1'b0, 1'b1, 16'h0, 1'b0, 1'b0}) begin
      fails++; $display("FAIL midreset: got v=%b r=%b %h/%b/%b want 0/1/0000/0/0", out_valid, in_ready, sum, cout, ovf);
    end
    #2 rst = 0;
    step();
    run_op(16'h0001, 16'h0001, 1'b0, s, c, o, lat); step();
    tests++; if ({s, c, o} !== {16'h0002, 1'b0, 1'b0} || lat !== 4) begin fails++; $display("FAIL midreset_after: got %h/%b/%b lat=%0d want 0002/0/0 lat=4", s, c, o, lat); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] xa[3] = '{16'h0001, 16'hF000, 16'h4000};
    logic [15:0] xb[3] = '{16'h0002, 16'h1000, 16'h4000};
    logic        xc[3] = '{1'b0, 1'b0, 1'b1};
    logic [17:0] exp_r[3] = '{{16'h0003, 1'b0, 1'b0}, {16'h0000, 1'b1, 1'b0}, {16'h8001, 1'b0, 1'b1}};
    int acc[3];
    int na = 0, nr = 0;
    out_ready = 1;
    a = xa[0]; b = xb[0]; cin = xc[0]; in_valid = 1;
    for (int cyc = 0; cyc < 40 && nr < 3; cyc++) begin
      if (out_valid) begin
        tests++; if ({sum, cout, ovf} !== exp_r[nr]) begin fails++; $display("FAIL b2b_result%0d: got %h want %h", nr, {sum, cout, ovf}, exp_r[nr]); end
        nr++;
      end
      if (in_ready && na < 3) begin
        acc[na] = cyc; na++;
        step();
        if (na < 3) begin a = xa[na]; b = xb[na]; cin = xc[na]; end else in_valid = 0;
      end else step();
    end
    in_valid = 0;
    tests++; if (na !== 3 || nr !== 3) begin fails++; $display("FAIL b2b_count: got accepted=%0d returned=%0d want 3/3", na, nr); end
    if (na == 3) begin
      tests++; if (acc[1] - acc[0] !== 6 || acc[2] - acc[1] !== 6) begin fails++; $display("FAIL b2b_spacing: got %0d,%0d want 6,6", acc[1] - acc[0], acc[2] - acc[1]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
